maxunpool: RTL
==============

# maxunpool

Streaming max-unpooling expander that performs the reverse of the pooling stage. It accepts one pooled value per transaction, together with the argmax position of that value inside a K-element window. It then emits the window serially as K output beats: the value appears at the argmax position and zero at every other position. Unpool mode can be switched off, in which case the value is replicated across all K positions (nearest-neighbour upsample). Both sides use a valid/ready handshake.

## Interface
- N, 32: signed data width of in_val and O.
- K, 4: window length in beats. Legal range 2..2^IW.
- IW, 2: width of the argmax index and position counter.
- clk  in  1: clock. All logic is on the rising edge.
- rst  in  1: synchronous, active-high reset.
- in_valid  in  1: input transaction offered.
- in_ready  out  1: block can accept an input this cycle.
- in_val  in  N: signed pooled value.
- in_idx  in  IW: argmax position inside the window, in the range 0..K-1.
- in_unpool  in  1: 1 selects zero-fill unpool; 0 selects replicate.
- out_valid  out  1: output beat present.
- out_ready  in  1: downstream accepts the beat this cycle.
- O  out  N: signed output beat.
- out_pos  out  IW: position of the current beat in the window, 0..K-1.
- out_last  out  1: current beat is position K-1.
- err  out  1: sticky flag, set when a transaction is accepted with in_idx >= K.

## Operation
- FSM states:
  - IDLE: no window in progress.
  - EMIT: window in progress.
- Registers:
  - val_q (N bits), idx_q (IW bits) and unpool_q: latched at input acceptance.
  - pos (IW bits): beat counter.
  - err: sticky flag.
- Input acceptance occurs when in_valid && in_ready.
  - On acceptance, latch in_val, in_idx and in_unpool, set pos=0 and enter EMIT.
- in_ready = !rst && (state==IDLE || (out_valid && out_ready && out_last)).
  - This gives a combinational path from out_ready to in_ready. That path is intentional and allows back-to-back windows with no bubble.
- In EMIT:
  - out_valid=1.
  - out_pos=pos.
  - out_last=(pos==K-1).
  - O is computed as follows:
    - If unpool_q=0: O=val_q.
    - If unpool_q=1: O=(pos==idx_q) ? val_q : 0.
- Beat completion (out_valid && out_ready):
  - If not the last beat: pos increments.
  - If the last beat and a new input is accepted in the same cycle: reload all latches, set pos=0, stay in EMIT.
  - If the last beat and no new input is accepted: go to IDLE.
- Out-of-range index: if an input is accepted with in_idx >= K, set err=1.
  - In unpool mode the window is emitted as K zero beats. No beat matches.
  - In replicate mode in_idx is ignored, but err is still set.
- err is cleared only by rst.
- Arithmetic: there is none on data. Values pass through bit-exact and are signed, e.g. -1 stays 32'hFFFFFFFF. Zero-fill beats are exactly 0.
- In IDLE, O, out_pos and out_last are 0.

## Timing
- Reset values: state=IDLE, out_valid=0, O=0, out_pos=0, out_last=0, err=0.
  - in_ready=0 while rst is high and 1 in the first cycle after rst deasserts.
- Latency: an input accepted at edge t produces its first beat (pos 0) with out_valid=1 in the cycle after t.
- Throughput: with out_ready held high, a window completes in exactly K cycles. Consecutive windows stream with zero idle cycles.
- Backpressure: while out_valid && !out_ready, O, out_pos and out_last hold stable. pos does not advance and in_ready=0.
- Simultaneous events:
  - Last-beat completion together with input acceptance in the same cycle: the new window's beat 0 appears in the next cycle.
  - rst together with any handshake: rst wins. The handshake is discarded and the state is forced to reset values.
- Reset mid-window: the window is abandoned with no further beats. The next accepted input starts at pos 0.
- in_valid while busy, not on the final accepted beat: ignored (in_ready=0). The sender must hold the input until accepted.

## Test plan
- Basic unpool, K=4: in_val=+9, in_idx=2, in_unpool=1, out_ready=1 -> beats 0,0,9,0 on consecutive cycles. out_last is high on the 4th beat only.
- Replicate: in_val=-4, in_unpool=0 -> beats -4,-4,-4,-4 (O=32'hFFFFFFFC). in_idx is ignored and err stays 0.
- Back-to-back: windows (5, idx 0) and (7, idx 3) are offered continuously -> 8 consecutive beats 5,0,0,0,0,0,0,7 with no gap. in_ready pulses high during the last beat of the first window.
- Backpressure: window (1, idx 1) with out_ready low for 3 cycles at beat 1 -> O=1 and out_pos=1 stay stable for all 3 cycles, then the remaining beats 0,0 follow.
- Bad index, K=3, IW=2: in_idx=3, in_val=6, in_unpool=1 -> beats 0,0,0 and err=1. err remains 1 across later valid windows until rst.
- Mid-window reset: rst asserted at beat 2 of a (9, idx 3) window -> next cycle out_valid=0, O=0. After rst deasserts, a new window (2, idx 0) emits 2,0,0,0.

Source files
------------

// File: rtl/maxunpool_if.sv
// Valid/ready bundle for the max-unpool expander: pooled input side and serial window output side.
interface maxunpool_if #(
    parameter int N  = 32,
    parameter int IW = 2
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [N-1:0]  in_val;
    logic [IW-1:0]        in_idx;
    logic                 in_unpool;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [N-1:0]  O;
    logic [IW-1:0]        out_pos;
    logic                 out_last;
    logic                 err;

    modport master (
        output in_valid, in_val, in_idx, in_unpool, out_ready,
        input  in_ready, out_valid, O, out_pos, out_last, err
    );

    modport slave (
        input  in_valid, in_val, in_idx, in_unpool, out_ready,
        output in_ready, out_valid, O, out_pos, out_last, err
    );
endinterface

// File: rtl/maxunpool.sv
// Streaming max-unpool expander: one pooled value in, K serial beats out with the value at
// the argmax slot (zero elsewhere), or replicated across the window when unpool is off.
module maxunpool #(
    parameter int N  = 32,
    parameter int K  = 4,
    parameter int IW = 2
) (
    input logic         clk,
    input logic         rst,
    maxunpool_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    localparam logic [IW-1:0] LAST_POS = IW'(K - 1);
    localparam logic [IW:0]   K_W      = (IW + 1)'(K);

    state_t              state_q, state_d;
    logic signed [N-1:0] val_q, val_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [IW-1:0]       pos_q, pos_d;
    logic                unpool_q, unpool_d;
    logic                err_q, err_d;
    logic                emit, last, beat_done, accept;

    always_comb begin
        state_d  = state_q;
        val_d    = val_q;
        idx_d    = idx_q;
        pos_d    = pos_q;
        unpool_d = unpool_q;
        err_d    = err_q;

        emit      = (state_q == EMIT);
        last      = emit && (pos_q == LAST_POS);
        beat_done = emit && bus.out_ready;
        // in_ready looks at out_ready combinationally so the next window can load on the last beat
        bus.in_ready = !rst && (!emit || (beat_done && last));
        accept       = bus.in_valid && bus.in_ready;

        bus.out_valid = emit;
        bus.out_pos   = emit ? pos_q : '0;
        bus.out_last  = last;
        bus.O         = (emit && (!unpool_q || pos_q == idx_q)) ? val_q : '0;
        bus.err       = err_q;

        if (beat_done) begin
            if (last) begin
                state_d = IDLE;
            end else begin
                pos_d = pos_q + 1'b1;
            end
        end

        if (accept) begin
            state_d  = EMIT;
            val_d    = bus.in_val;
            idx_d    = bus.in_idx;
            unpool_d = bus.in_unpool;
            pos_d    = '0;
            if ({1'b0, bus.in_idx} >= K_W) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            val_q    <= '0;
            idx_q    <= '0;
            pos_q    <= '0;
            unpool_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            val_q    <= val_d;
            idx_q    <= idx_d;
            pos_q    <= pos_d;
            unpool_q <= unpool_d;
            err_q    <= err_d;
        end
    end
endmodule
